mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles (0..7) per memory access state.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-005 The block SHALL have port halt_req  input  1  return to IDLE at the next instruction boundary.
REQ-006 The block SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-007 The block SHALL have port funct  input  6  instruction bits [5:0].
REQ-008 The block SHALL have port zero  input  1  ALU zero flag, same cycle.
REQ-009 The block SHALL have output ports, each 1 bit unless stated: pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b(2), alu_ctrl(2, 00 add/01 sub), pc_src, busy, instr_done, illegal.

Function
REQ-010 The block SHALL implement states IDLE, FETCH, DECODE, EXEC_R, EXEC_ADDI, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH, ILLEGAL.
REQ-011 IDLE SHALL go to FETCH when start=1 and stay otherwise; busy=0 only in IDLE and ILLEGAL.
REQ-012 FETCH SHALL assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=00 for MEM_WAIT+1 cycles; only on the final cycle assert ir_write, pc_write, pc_src=0, then go to DECODE.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_ctrl=00 (branch target into ALUOut) and dispatch on opcode/funct.
REQ-014 Dispatch SHALL be: 0x00 with funct 0x20/0x22 -> EXEC_R; 0x08 -> EXEC_ADDI; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; anything else, including opcode 0x00 with another funct -> ILLEGAL.
REQ-015 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=00 for funct 0x20 or 01 for 0x22, then go to R_WB.
REQ-016 R_WB SHALL assert reg_write, reg_dst=1, mem_to_reg=0.
REQ-017 EXEC_ADDI SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=00, then go to ADDI_WB, which asserts reg_write, reg_dst=0, mem_to_reg=0.
REQ-018 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=00, then go to MEM_RD (0x23) or MEM_WR (0x2B).
REQ-019 MEM_RD SHALL hold mem_read=1 and i_or_d=1 for MEM_WAIT+1 cycles, then go to MEM_WB, which asserts reg_write, reg_dst=0, mem_to_reg=1.
REQ-020 MEM_WR SHALL hold i_or_d=1 for MEM_WAIT+1 cycles, asserting mem_write only on the final cycle (exactly one write pulse).
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=01, pc_src=1, with pc_write=zero for 0x04 and pc_write=~zero for 0x05; pc_write is the only Mealy output.
REQ-022 The wait counter SHALL be 3 bits, SHALL clear on entry to every wait state, and SHALL never wrap.
REQ-023 R_WB, ADDI_WB, MEM_WB, the final MEM_WR cycle and BRANCH SHALL each pulse instr_done for 1 cycle, then go to IDLE if halt_req=1, otherwise to FETCH.
REQ-024 halt_req SHALL be sampled only at instruction boundaries and SHALL NOT abort an instruction in flight.
REQ-025 ILLEGAL SHALL assert illegal=1 and SHALL hold with all strobes 0 until reset; start is ignored.
REQ-026 All outputs not listed for a state SHALL be 0.
REQ-027 With MEM_WAIT=0, cycles per instruction SHALL be R/addi/sw 4, lw 5, beq/bne 3; each memory state adds MEM_WAIT.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, and every output 0, including mid-instruction and mid-write.
REQ-029 After rst_n rises, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-030 MEM_WAIT=0, start, opcode 0x00/funct 0x20 -> ir_write+pc_write at cycle 1, reg_write+reg_dst at cycle 4, instr_done at cycle 4, next FETCH at cycle 5.
REQ-031 lw (0x23) then sw (0x2B) -> reg_write+mem_to_reg on the 5th cycle; exactly one mem_write pulse on the 4th cycle of sw, with i_or_d=1.
REQ-032 bne with zero=0 -> pc_write=1, pc_src=1 in BRANCH; beq with zero=0 -> pc_write=0; both complete in 3 cycles.
REQ-033 MEM_WAIT=2, lw -> mem_read held 3 cycles in FETCH and 3 in MEM_RD, ir_write only on the 3rd FETCH cycle, total 9 cycles.
REQ-034 opcode 0x3F -> ILLEGAL with illegal=1 and busy=0; start pulses are ignored; rst_n low then high -> IDLE with illegal=0.
REQ-035 rst_n low during MEM_WR of sw with MEM_WAIT=3 -> no mem_write pulse and all outputs 0; halt_req high during an addi -> addi completes, then IDLE.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit for add/sub/addi/lw/sw/beq/bne with a configurable
// number of memory wait cycles. Outputs are registered except the branch pc_write.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt_req,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic       pc_src,
  output logic       busy,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_ADDI, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_R_WB, S_ADDI_WB, S_BRANCH, S_ILLEGAL
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_WAIT);

  state_t     state, nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pc_write_q;
  logic       boundary_next;
  logic       stay_wait;

  always_comb begin
    nxt = state;
    boundary_next = 1'b0;
    unique case (state)
      S_IDLE:      if (start) nxt = S_FETCH;
      S_FETCH:     if (cnt == LAST) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          6'h00:        nxt = (funct == 6'h20 || funct == 6'h22) ? S_EXEC_R : S_ILLEGAL;
          6'h08:        nxt = S_EXEC_ADDI;
          6'h23, 6'h2B: nxt = S_MEM_ADDR;
          6'h04, 6'h05: nxt = S_BRANCH;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    nxt = S_R_WB;
      S_EXEC_ADDI: nxt = S_ADDI_WB;
      S_MEM_ADDR:  nxt = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (cnt == LAST) nxt = S_MEM_WB;
      S_MEM_WR:    if (cnt == LAST) boundary_next = 1'b1;
      S_R_WB, S_ADDI_WB, S_MEM_WB, S_BRANCH: boundary_next = 1'b1;
      S_ILLEGAL:   nxt = S_ILLEGAL;
      default:     nxt = S_IDLE;
    endcase
    // halt_req only matters once the current instruction has retired
    if (boundary_next) nxt = halt_req ? S_IDLE : S_FETCH;
  end

  // The counter advances only while a wait state repeats; any state change clears it
  always_comb begin
    stay_wait = (nxt == state) && (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
    if (stay_wait) cnt_nxt = (cnt == 3'd7) ? cnt : cnt + 3'd1;
    else           cnt_nxt = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      pc_write_q <= 1'b0;
      i_or_d     <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ir_write   <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_dst    <= 1'b0;
      reg_write  <= 1'b0;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      alu_ctrl   <= 2'b00;
      pc_src     <= 1'b0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      pc_write_q <= 1'b0;
      i_or_d     <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ir_write   <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_dst    <= 1'b0;
      reg_write  <= 1'b0;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      alu_ctrl   <= 2'b00;
      pc_src     <= 1'b0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      busy       <= (nxt != S_IDLE) && (nxt != S_ILLEGAL);
      unique case (nxt)
        S_FETCH: begin
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
          if (cnt_nxt == LAST) begin
            ir_write   <= 1'b1;
            pc_write_q <= 1'b1;
          end
        end
        S_DECODE:    alu_src_b <= 2'b11;
        S_EXEC_R: begin
          alu_src_a <= 1'b1;
          alu_ctrl  <= (funct == 6'h22) ? 2'b01 : 2'b00;
        end
        S_EXEC_ADDI, S_MEM_ADDR: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        S_MEM_RD: begin
          mem_read <= 1'b1;
          i_or_d   <= 1'b1;
        end
        S_MEM_WR: begin
          i_or_d <= 1'b1;
          if (cnt_nxt == LAST) begin
            mem_write  <= 1'b1;
            instr_done <= 1'b1;
          end
        end
        S_MEM_WB: begin
          reg_write  <= 1'b1;
          mem_to_reg <= 1'b1;
          instr_done <= 1'b1;
        end
        S_R_WB: begin
          reg_write  <= 1'b1;
          reg_dst    <= 1'b1;
          instr_done <= 1'b1;
        end
        S_ADDI_WB: begin
          reg_write  <= 1'b1;
          instr_done <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  <= 1'b1;
          alu_ctrl   <= 2'b01;
          pc_src     <= 1'b1;
          instr_done <= 1'b1;
        end
        S_ILLEGAL:   illegal <= 1'b1;
        default:     ;
      endcase
    end
  end

  // Branch decision needs the live zero flag, so this strobe is combinational in BRANCH
  assign pc_write = pc_write_q |
                    ((state == S_BRANCH) && ((opcode == 6'h05) ? ~zero : zero));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: three controllers (MEM_WAIT 0, 2, 3) compared cycle by cycle
// against per-instruction output schedules derived from the instruction timing rules.
module tb_mips_multicycle_ctrl;

  localparam logic [16:0] PCW     = 17'h10000;
  localparam logic [16:0] IORD    = 17'h08000;
  localparam logic [16:0] MRD     = 17'h04000;
  localparam logic [16:0] MWR     = 17'h02000;
  localparam logic [16:0] IRW     = 17'h01000;
  localparam logic [16:0] M2R     = 17'h00800;
  localparam logic [16:0] RDST    = 17'h00400;
  localparam logic [16:0] RW      = 17'h00200;
  localparam logic [16:0] SRCA    = 17'h00100;
  localparam logic [16:0] SRCB_10 = 17'h00080;
  localparam logic [16:0] SRCB_01 = 17'h00040;
  localparam logic [16:0] SRCB_11 = 17'h000C0;
  localparam logic [16:0] SUB     = 17'h00010;
  localparam logic [16:0] PCSRC   = 17'h00008;
  localparam logic [16:0] BUSY    = 17'h00004;
  localparam logic [16:0] DONE    = 17'h00002;
  localparam logic [16:0] ILL     = 17'h00001;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s [3];
  logic       start_s [3];
  logic       halt_s  [3];
  logic       zero_s  [3];
  logic [5:0] op_s    [3];
  logic [5:0] fn_s    [3];

  logic       pcw_o [3], iord_o [3], mrd_o [3], mwr_o [3], irw_o [3], m2r_o [3];
  logic       rdst_o [3], rw_o [3], srca_o [3], pcsrc_o [3], busy_o [3], done_o [3], ill_o [3];
  logic [1:0] srcb_o [3], aluc_o [3];
  logic [16:0] obs [3];

  int vectors = 0;
  int miscompares = 0;
  instr_t prog [$];
  logic [16:0] sched [$];

  mips_multicycle_ctrl #(.MEM_WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .halt_req(halt_s[0]),
    .opcode(op_s[0]), .funct(fn_s[0]), .zero(zero_s[0]),
    .pc_write(pcw_o[0]), .i_or_d(iord_o[0]), .mem_read(mrd_o[0]), .mem_write(mwr_o[0]),
    .ir_write(irw_o[0]), .mem_to_reg(m2r_o[0]), .reg_dst(rdst_o[0]), .reg_write(rw_o[0]),
    .alu_src_a(srca_o[0]), .alu_src_b(srcb_o[0]), .alu_ctrl(aluc_o[0]), .pc_src(pcsrc_o[0]),
    .busy(busy_o[0]), .instr_done(done_o[0]), .illegal(ill_o[0]));

  mips_multicycle_ctrl #(.MEM_WAIT(2)) u_w2 (
    .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .halt_req(halt_s[1]),
    .opcode(op_s[1]), .funct(fn_s[1]), .zero(zero_s[1]),
    .pc_write(pcw_o[1]), .i_or_d(iord_o[1]), .mem_read(mrd_o[1]), .mem_write(mwr_o[1]),
    .ir_write(irw_o[1]), .mem_to_reg(m2r_o[1]), .reg_dst(rdst_o[1]), .reg_write(rw_o[1]),
    .alu_src_a(srca_o[1]), .alu_src_b(srcb_o[1]), .alu_ctrl(aluc_o[1]), .pc_src(pcsrc_o[1]),
    .busy(busy_o[1]), .instr_done(done_o[1]), .illegal(ill_o[1]));

  mips_multicycle_ctrl #(.MEM_WAIT(3)) u_w3 (
    .clk(clk), .rst_n(rst_n_s[2]), .start(start_s[2]), .halt_req(halt_s[2]),
    .opcode(op_s[2]), .funct(fn_s[2]), .zero(zero_s[2]),
    .pc_write(pcw_o[2]), .i_or_d(iord_o[2]), .mem_read(mrd_o[2]), .mem_write(mwr_o[2]),
    .ir_write(irw_o[2]), .mem_to_reg(m2r_o[2]), .reg_dst(rdst_o[2]), .reg_write(rw_o[2]),
    .alu_src_a(srca_o[2]), .alu_src_b(srcb_o[2]), .alu_ctrl(aluc_o[2]), .pc_src(pcsrc_o[2]),
    .busy(busy_o[2]), .instr_done(done_o[2]), .illegal(ill_o[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {pcw_o[g], iord_o[g], mrd_o[g], mwr_o[g], irw_o[g], m2r_o[g], rdst_o[g],
                     rw_o[g], srca_o[g], srcb_o[g], aluc_o[g], pcsrc_o[g], busy_o[g],
                     done_o[g], ill_o[g]};
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  // Expected per-cycle outputs for one instruction, from first FETCH cycle to retirement
  task automatic model_schedule(input instr_t in, input int w, output bit ill);
    bit taken;
    sched.delete();
    ill = 1'b0;
    for (int i = 0; i <= w; i++)
      sched.push_back(BUSY | MRD | SRCB_01 | ((i == w) ? (IRW | PCW) : 17'h0));
    sched.push_back(BUSY | SRCB_11);
    if (in.op == 6'h00 && (in.fn == 6'h20 || in.fn == 6'h22)) begin
      sched.push_back(BUSY | SRCA | ((in.fn == 6'h22) ? SUB : 17'h0));
      sched.push_back(BUSY | RW | RDST | DONE);
    end else if (in.op == 6'h08) begin
      sched.push_back(BUSY | SRCA | SRCB_10);
      sched.push_back(BUSY | RW | DONE);
    end else if (in.op == 6'h23) begin
      sched.push_back(BUSY | SRCA | SRCB_10);
      for (int i = 0; i <= w; i++) sched.push_back(BUSY | MRD | IORD);
      sched.push_back(BUSY | RW | M2R | DONE);
    end else if (in.op == 6'h2B) begin
      sched.push_back(BUSY | SRCA | SRCB_10);
      for (int i = 0; i <= w; i++)
        sched.push_back(BUSY | IORD | ((i == w) ? (MWR | DONE) : 17'h0));
    end else if (in.op == 6'h04 || in.op == 6'h05) begin
      taken = (in.op == 6'h04) ? in.z : !in.z;
      sched.push_back(BUSY | SRCA | SUB | PCSRC | DONE | (taken ? PCW : 17'h0));
    end else begin
      ill = 1'b1;
      for (int i = 0; i < 4; i++) sched.push_back(ILL);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z);
    instr_t r;
    r.op = op; r.fn = fn; r.z = z;
    return r;
  endfunction

  function automatic instr_t rand_instr(input bit allow_ill);
    int r;
    logic [5:0] op, fn;
    logic z;
    r = $urandom_range(0, allow_ill ? 8 : 6);
    z = 1'($urandom_range(0, 1));
    fn = 6'($urandom_range(0, 63));
    case (r)
      0: begin op = 6'h00; fn = 6'h20; end
      1: begin op = 6'h00; fn = 6'h22; end
      2: op = 6'h08;
      3: op = 6'h23;
      4: op = 6'h2B;
      5: op = 6'h04;
      6: op = 6'h05;
      7: begin
        op = 6'h00;
        while (fn == 6'h20 || fn == 6'h22) fn = 6'($urandom_range(0, 63));
      end
      default: begin
        op = 6'($urandom_range(1, 63));
        while (op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05)
          op = 6'($urandom_range(1, 63));
      end
    endcase
    return mk(op, fn, z);
  endfunction

  task automatic do_reset(input int k);
    rst_n_s[k] = 1'b0;
    #1;
    vectors++;
    if (obs[k] !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_async k=%0d: got %h expected %h", k, obs[k], 17'h0);
    end
    @(negedge clk);
    vectors++;
    if (obs[k] !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold k=%0d: got %h expected %h", k, obs[k], 17'h0);
    end
    start_s[k] = 1'b0;
    halt_s[k]  = 1'b0;
    rst_n_s[k] = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs[k] !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset k=%0d: got %h expected %h", k, obs[k], 17'h0);
    end
  endtask

  // Runs prog on instance k from IDLE; halts after the last instruction.
  // abort_cycle >= 0 pulls reset at that cycle index; halt_hold keeps halt_req high mid-instruction.
  task automatic run_prog(input int k, input int abort_cycle, input bit halt_hold);
    bit ill;
    int cyc = 0;
    bit last;
    @(negedge clk);
    vectors++;
    if (obs[k] !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL idle_before_start k=%0d: got %h expected %h", k, obs[k], 17'h0);
    end
    start_s[k] = 1'b1;
    for (int n = 0; n < prog.size(); n++) begin
      op_s[k]   = prog[n].op;
      fn_s[k]   = prog[n].fn;
      zero_s[k] = prog[n].z;
      model_schedule(prog[n], wait_of(k), ill);
      for (int c = 0; c < sched.size(); c++) begin
        @(negedge clk);
        if (cyc == abort_cycle) begin
          do_reset(k);
          return;
        end
        cyc++;
        vectors++;
        if (obs[k] !== sched[c]) begin
          miscompares++;
          $display("[TB] FAIL sched k=%0d op=%h fn=%h cyc=%0d: got %h expected %h",
                   k, prog[n].op, prog[n].fn, c + 1, obs[k], sched[c]);
        end
        last = (c == sched.size() - 1);
        start_s[k] = last ? 1'b0 : 1'($urandom_range(0, 1));
        halt_s[k]  = last ? (n == prog.size() - 1) : (halt_hold ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      if (ill) begin
        do_reset(k);
        return;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (obs[k] !== 17'h0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_halt k=%0d: got %h expected %h", k, obs[k], 17'h0);
      end
      halt_s[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) do_reset(k);
  endtask

  task automatic test_r_type();
    prog.delete();
    prog.push_back(mk(6'h00, 6'h20, 1'b0));
    prog.push_back(mk(6'h00, 6'h22, 1'b1));
    run_prog(0, -1, 1'b0);
  endtask

  task automatic test_load_store();
    prog.delete();
    prog.push_back(mk(6'h23, 6'h00, 1'b0));
    prog.push_back(mk(6'h2B, 6'h00, 1'b0));
    run_prog(0, -1, 1'b0);
  endtask

  task automatic test_branch();
    prog.delete();
    prog.push_back(mk(6'h05, 6'h00, 1'b0));
    prog.push_back(mk(6'h04, 6'h00, 1'b0));
    prog.push_back(mk(6'h04, 6'h11, 1'b1));
    prog.push_back(mk(6'h05, 6'h11, 1'b1));
    run_prog(0, -1, 1'b0);
  endtask

  task automatic test_wait_states();
    prog.delete();
    prog.push_back(mk(6'h23, 6'h00, 1'b0));
    prog.push_back(mk(6'h2B, 6'h00, 1'b1));
    run_prog(1, -1, 1'b0);
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(mk(6'h3F, 6'h00, 1'b0));
    run_prog(0, -1, 1'b0);
    prog.delete();
    prog.push_back(mk(6'h08, 6'h00, 1'b0));
    prog.push_back(mk(6'h00, 6'h21, 1'b0));
    run_prog(2, -1, 1'b0);
  endtask

  task automatic test_reset_midwrite();
    // MEM_WAIT=3 sw: FETCH 0-3, DECODE 4, MEM_ADDR 5, MEM_WR 6-9 (write on 9)
    prog.delete();
    prog.push_back(mk(6'h2B, 6'h00, 1'b0));
    run_prog(2, 8, 1'b0);
  endtask

  task automatic test_halt_addi();
    prog.delete();
    prog.push_back(mk(6'h08, 6'h00, 1'b0));
    run_prog(0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 3; k++) begin
        prog.delete();
        for (int i = 0; i < 10; i++) prog.push_back(rand_instr(1'b0));
        if ($urandom_range(0, 3) == 0) prog.push_back(rand_instr(1'b1));
        run_prog(k, -1, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n_s[k] = 1'b1;
      start_s[k] = 1'b0;
      halt_s[k]  = 1'b0;
      zero_s[k]  = 1'b0;
      op_s[k]    = 6'h00;
      fn_s[k]    = 6'h00;
    end
    @(negedge clk);
    test_reset();
    test_r_type();
    test_load_store();
    test_branch();
    test_wait_states();
    test_illegal();
    test_reset_midwrite();
    test_halt_addi();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
